dds_multi_gen: RTL and testbench

Multi-channel direct-digital-synthesis waveform generator: N_CH independent phase accumulators, each driving a 4-stage pipeline that produces sine, square, triangle or sawtooth samples in offset-binary for the DAC outputs. Per-channel frequency, phase offset, gain and mode are written into shadow registers and applied to all channels atomically on a commit strobe. A commit can optionally re-align all accumulators, which gives phase-coherent channels. Sits between the front-panel/UART configuration logic and the DAC pins.

---
 rtl/dds_multi_gen.sv | 193 +++++++++++++++++++
 tb/tb_dds_multi_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multi_gen.sv
// Multi-channel DDS generator: per-channel phase accumulator feeding a 4-stage
// sine/square/triangle/saw pipeline with shadowed, atomically committed settings.
module dds_multi_gen #(
   parameter  int N_CH   = 2,
   parameter  int ACC_W  = 24,
   parameter  int LUT_AW = 9,
   parameter  int DAC_W  = 14,
   parameter  int PH_W   = 9,
   parameter  int AMP_W  = 8,
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CH-1:0]        en,
   input  logic                   cfg_wr,
   input  logic [CH_W-1:0]        cfg_ch,
   input  logic [1:0]             cfg_sel,
   input  logic [ACC_W-1:0]       cfg_data,
   input  logic                   cfg_commit,
   input  logic                   cfg_sync,
   output logic [N_CH*DAC_W-1:0]  dac_out,
   output logic [N_CH-1:0]        wrap
);

   typedef enum logic [1:0] {MODE_SINE, MODE_SQUARE, MODE_TRI, MODE_SAW} mode_t;

   localparam int              MID     = 2 ** (DAC_W - 1);
   localparam int              PW      = DAC_W + AMP_W + 3;
   localparam logic [AMP_W:0]  AMP_ONE = {1'b1, {AMP_W{1'b0}}};

   // Elaboration-time sine entry: offset-binary, amplitude MID-1, Taylor series in Q30.
   function automatic int f_sin_entry(input int unsigned idx);
      longint n, q, j, x, x2, term, s, mag;
      bit     neg;
      n   = longint'(2 ** LUT_AW);
      q   = n / 4;
      j   = longint'(idx) % (n / 2);
      neg = (longint'(idx) >= n / 2);
      if (j > q) j = n / 2 - j;
      x    = j * 64'sd1686629713 / q;
      x2   = (x * x) >>> 30;
      term = x;
      s    = x;
      for (int unsigned k = 1; k <= 5; k++) begin
         term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
         s    = s + term;
      end
      mag = (s * longint'(MID - 1) + (64'sd1 <<< 29)) >>> 30;
      return neg ? (MID - int'(mag)) : (MID + int'(mag));
   endfunction

   logic [DAC_W-1:0] w_lut [2**LUT_AW];

   for (genvar gi = 0; gi < 2**LUT_AW; gi++) begin : g_lut
      assign w_lut[gi] = DAC_W'(f_sin_entry(gi));
   end

   logic [ACC_W-1:0] r_sh_freq  [N_CH];
   logic [PH_W-1:0]  r_sh_phase [N_CH];
   logic [AMP_W:0]   r_sh_amp   [N_CH];
   mode_t            r_sh_mode  [N_CH];
   logic [ACC_W-1:0] r_ac_freq  [N_CH];
   logic [PH_W-1:0]  r_ac_phase [N_CH];
   logic [AMP_W:0]   r_ac_amp   [N_CH];
   mode_t            r_ac_mode  [N_CH];

   logic [ACC_W-1:0] r_acc   [N_CH];
   logic [N_CH-1:0]  r_carry0, r_en0;
   logic [DAC_W-1:0] r_ph    [N_CH];
   logic [AMP_W:0]   r_amp1  [N_CH];
   mode_t            r_mode1 [N_CH];
   logic [N_CH-1:0]  r_carry1, r_en1;
   logic [DAC_W-1:0] r_samp  [N_CH];
   logic [AMP_W:0]   r_amp2  [N_CH];
   logic [N_CH-1:0]  r_carry2, r_en2;

   logic signed [DAC_W:0] w_diff [N_CH];
   logic signed [PW-1:0]  w_prod [N_CH];
   logic [DAC_W-1:0]      w_out  [N_CH];
   logic [N_CH-1:0]       w_unused_bits;

   // Commit copies the pre-edge shadow, so a write on the commit cycle lands in shadow only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < N_CH; c++) begin
            r_sh_freq[c]  <= '0;
            r_sh_phase[c] <= '0;
            r_sh_amp[c]   <= AMP_ONE;
            r_sh_mode[c]  <= MODE_SINE;
            r_ac_freq[c]  <= '0;
            r_ac_phase[c] <= '0;
            r_ac_amp[c]   <= AMP_ONE;
            r_ac_mode[c]  <= MODE_SINE;
         end
      end else begin
         if (cfg_commit) begin
            r_ac_freq  <= r_sh_freq;
            r_ac_phase <= r_sh_phase;
            r_ac_amp   <= r_sh_amp;
            r_ac_mode  <= r_sh_mode;
         end
         if (cfg_wr && (int'(cfg_ch) < N_CH)) begin
            case (cfg_sel)
               2'd0:    r_sh_freq[cfg_ch]  <= cfg_data;
               2'd1:    r_sh_phase[cfg_ch] <= cfg_data[PH_W-1:0];
               2'd2:    r_sh_amp[cfg_ch]   <= (cfg_data > ACC_W'(AMP_ONE)) ? AMP_ONE
                                                                             : cfg_data[AMP_W:0];
               default: r_sh_mode[cfg_ch]  <= mode_t'(cfg_data[1:0]);
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < N_CH; c++) r_acc[c] <= '0;
         r_carry0 <= '0;
         r_en0    <= '0;
      end else begin
         r_en0 <= en;
         for (int unsigned c = 0; c < N_CH; c++) begin
            if (cfg_commit && cfg_sync) begin
               r_acc[c]    <= '0;
               r_carry0[c] <= 1'b0;
            end else if (en[c]) begin
               {r_carry0[c], r_acc[c]} <= {1'b0, r_acc[c]} + {1'b0, r_ac_freq[c]};
            end else begin
               r_acc[c]    <= '0;
               r_carry0[c] <= 1'b0;
            end
         end
      end
   end

   // Only the top DAC_W phase bits feed the waveform stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < N_CH; c++) begin
            r_ph[c]    <= '0;
            r_amp1[c]  <= '0;
            r_mode1[c] <= MODE_SINE;
            r_samp[c]  <= '0;
            r_amp2[c]  <= '0;
         end
         r_en1    <= '0;
         r_carry1 <= '0;
         r_en2    <= '0;
         r_carry2 <= '0;
      end else begin
         r_en1    <= r_en0;
         r_carry1 <= r_carry0;
         r_en2    <= r_en1;
         r_carry2 <= r_carry1;
         for (int unsigned c = 0; c < N_CH; c++) begin
            r_ph[c]    <= DAC_W'((r_acc[c] + {r_ac_phase[c], {(ACC_W-PH_W){1'b0}}})
                                 >> (ACC_W - DAC_W));
            r_amp1[c]  <= r_ac_amp[c];
            r_mode1[c] <= r_ac_mode[c];
            r_amp2[c]  <= r_amp1[c];
            case (r_mode1[c])
               MODE_SINE:   r_samp[c] <= w_lut[r_ph[c][DAC_W-1 -: LUT_AW]];
               MODE_SQUARE: r_samp[c] <= r_ph[c][DAC_W-1] ? '0 : '1;
               MODE_TRI:    r_samp[c] <= r_ph[c][DAC_W-1] ? ~{r_ph[c][DAC_W-2:0], 1'b0}
                                                          :  {r_ph[c][DAC_W-2:0], 1'b0};
               default:     r_samp[c] <= r_ph[c];
            endcase
         end
      end
   end

   // Bits [AMP_W +: DAC_W] of the product are the arithmetic-shifted result modulo 2^DAC_W.
   always_comb begin
      for (int unsigned c = 0; c < N_CH; c++) begin
         w_diff[c]        = $signed({1'b0, r_samp[c]}) - $signed((DAC_W+1)'(MID));
         w_prod[c]        = PW'(w_diff[c]) * PW'($signed({1'b0, r_amp2[c]}));
         w_out[c]         = DAC_W'(MID) + w_prod[c][AMP_W +: DAC_W];
         w_unused_bits[c] = ^{w_prod[c][PW-1 -: 3], w_prod[c][AMP_W-1:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dac_out <= '0;
         wrap    <= '0;
      end else begin
         for (int unsigned c = 0; c < N_CH; c++) begin
            dac_out[c*DAC_W +: DAC_W] <= r_en2[c] ? w_out[c] : '0;
            wrap[c]                   <= r_en2[c] & r_carry2[c];
         end
      end
   end

endmodule

// File: tb/tb_dds_multi_gen.sv
// Randomised and directed bench for dds_multi_gen against an arithmetic
// reference model of the phase/sample/gain rules with a 3-edge output delay line.
module tb_dds_multi_gen;
   localparam int     N_CH    = 2;
   localparam int     ACC_W   = 24;
   localparam int     LUT_AW  = 9;
   localparam int     DAC_W   = 14;
   localparam int     PH_W    = 9;
   localparam int     AMP_W   = 8;
   localparam longint ACC_MOD = 64'd1 << ACC_W;
   localparam int     MID     = 1 << (DAC_W - 1);
   localparam int     FULL    = (1 << DAC_W) - 1;
   localparam int     UNITY   = 1 << AMP_W;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [N_CH-1:0]       en = '0;
   logic                  cfg_wr = 1'b0;
   logic [0:0]            cfg_ch = '0;
   logic [1:0]            cfg_sel = '0;
   logic [ACC_W-1:0]      cfg_data = '0;
   logic                  cfg_commit = 1'b0;
   logic                  cfg_sync = 1'b0;
   logic [N_CH*DAC_W-1:0] dac_out;
   logic [N_CH-1:0]       wrap;

   dds_multi_gen #(
      .N_CH(N_CH), .ACC_W(ACC_W), .LUT_AW(LUT_AW),
      .DAC_W(DAC_W), .PH_W(PH_W), .AMP_W(AMP_W)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .cfg_sync(cfg_sync),
      .dac_out(dac_out), .wrap(wrap)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   longint m_sh_freq [N_CH], m_ac_freq [N_CH], m_acc [N_CH];
   int     m_sh_ph   [N_CH], m_ac_ph   [N_CH];
   int     m_sh_amp  [N_CH], m_ac_amp  [N_CH];
   int     m_sh_mode [N_CH], m_ac_mode [N_CH];
   // Expected samples, N_CH entries per edge, oldest first.
   int     q_dac[$];
   int     q_wrap[$];
   int     q_tol[$];

   task automatic check_val(input string tag, input int obs, input int exp, input int tol = 0);
      n_cmp++;
      if (obs < exp - tol || obs > exp + tol) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
      end
   endtask

   function automatic int sine_ref(input int idx);
      real r;
      r = real'(MID - 1) * $sin(2.0 * 3.14159265358979 * real'(idx) / real'(1 << LUT_AW));
      return (r >= 0.0) ? MID + $rtoi(r + 0.5) : MID - $rtoi(-r + 0.5);
   endfunction

   function automatic int floor_div(input int d, input int s);
      return (d >= 0) ? d / s : -((-d + s - 1) / s);
   endfunction

   function automatic int ch_val(input int c);
      return int'(dac_out[c*DAC_W +: DAC_W]);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_sh_freq[c] = 0; m_ac_freq[c] = 0; m_acc[c] = 0;
         m_sh_ph[c]   = 0; m_ac_ph[c]   = 0;
         m_sh_amp[c]  = UNITY; m_ac_amp[c] = UNITY;
         m_sh_mode[c] = 0; m_ac_mode[c] = 0;
      end
      q_dac.delete(); q_wrap.delete(); q_tol.delete();
      for (int i = 0; i < 3 * N_CH; i++) begin
         q_dac.push_back(0); q_wrap.push_back(0); q_tol.push_back(0);
      end
   endtask

   task automatic model_step();
      bit     carry [N_CH];
      longint sum, ph;
      int     p, samp, d;
      for (int c = 0; c < N_CH; c++) begin
         carry[c] = 1'b0;
         if (cfg_commit && cfg_sync) m_acc[c] = 0;
         else if (en[c]) begin
            sum      = m_acc[c] + m_ac_freq[c];
            carry[c] = (sum >= ACC_MOD);
            m_acc[c] = sum % ACC_MOD;
         end else m_acc[c] = 0;
      end
      if (cfg_commit) begin
         m_ac_freq = m_sh_freq; m_ac_ph = m_sh_ph; m_ac_amp = m_sh_amp; m_ac_mode = m_sh_mode;
      end
      if (cfg_wr && int'(cfg_ch) < N_CH) begin
         case (cfg_sel)
            2'd0: m_sh_freq[cfg_ch] = longint'(cfg_data);
            2'd1: m_sh_ph[cfg_ch]   = int'(cfg_data) % (1 << PH_W);
            2'd2: m_sh_amp[cfg_ch]  = (int'(cfg_data) > UNITY) ? UNITY : int'(cfg_data);
            default: m_sh_mode[cfg_ch] = int'(cfg_data) % 4;
         endcase
      end
      for (int c = 0; c < N_CH; c++) begin
         ph = (m_acc[c] + longint'(m_ac_ph[c]) * (64'd1 << (ACC_W - PH_W))) % ACC_MOD;
         p  = int'(ph >> (ACC_W - DAC_W));
         case (m_ac_mode[c])
            0: samp = sine_ref(int'(ph >> (ACC_W - LUT_AW)));
            1: samp = (p < MID) ? FULL : 0;
            2: samp = (p < MID) ? 2 * p : FULL - 2 * (p - MID);
            default: samp = p;
         endcase
         d = (samp - MID) * m_ac_amp[c];
         q_dac.push_back(en[c] ? MID + floor_div(d, UNITY) : 0);
         q_wrap.push_back((en[c] && carry[c]) ? 1 : 0);
         q_tol.push_back((en[c] && m_ac_mode[c] == 0) ? 1 : 0);
      end
   endtask

   task automatic tick();
      int e_dac, e_wrap, e_tol;
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      for (int c = 0; c < N_CH; c++) begin
         if (rst) begin
            e_dac = 0; e_wrap = 0; e_tol = 0;
         end else begin
            e_dac  = q_dac.pop_front();
            e_wrap = q_wrap.pop_front();
            e_tol  = q_tol.pop_front();
         end
         check_val($sformatf("dac%0d", c), ch_val(c), e_dac, e_tol);
         check_val($sformatf("wrap%0d", c), int'(wrap[c]), e_wrap);
      end
   endtask

   task automatic drive(input bit wr, input int ch, input int sel, input longint data,
                        input bit com = 1'b0, input bit syn = 1'b0);
      cfg_wr = wr; cfg_ch = 1'(ch); cfg_sel = 2'(sel); cfg_data = ACC_W'(data);
      cfg_commit = com; cfg_sync = syn;
      tick();
      cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_sync = 1'b0;
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      check_val("async_dac", int'(dac_out), 0);
      check_val("async_wrap", int'(wrap), 0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      en = '1;
      repeat (4) tick();
      check_val("reset_sine", ch_val(0), MID);

      // saw, freq 1024, sync commit: counts 0,1,2,... and wraps every 16384 samples
      drive(1, 0, 3, 3);
      drive(1, 0, 0, 1024);
      drive(0, 0, 0, 0, 1, 1);
      repeat (2) tick();
      tick();
      check_val("saw_k3", ch_val(0), 0);
      tick();
      check_val("saw_k4", ch_val(0), 1);
      repeat (16390) tick();

      // freq 2048 committed while a 4096 write on the commit cycle stays in shadow
      drive(1, 0, 0, 2048);
      drive(1, 0, 0, 4096, 1, 0);
      repeat (10) tick();
      drive(0, 0, 0, 0, 1, 0);
      repeat (10) tick();

      // gain: half, zero, then over-range saturating to unity
      drive(1, 0, 2, 128, 1, 0);
      drive(0, 0, 0, 0, 1, 0);
      repeat (8) tick();
      drive(1, 0, 2, 0);
      drive(0, 0, 0, 0, 1, 0);
      repeat (3) tick();
      check_val("amp0", ch_val(0), MID);
      drive(1, 0, 2, 400);
      drive(0, 0, 0, 0, 1, 0);
      repeat (8) tick();

      // square on both channels, phase-coherent, then ch1 shifted by 180 degrees
      for (int c = 0; c < N_CH; c++) begin
         drive(1, c, 3, 1);
         drive(1, c, 0, 1 << 22);
         drive(1, c, 1, 0);
      end
      drive(0, 0, 0, 0, 1, 1);
      repeat (3) tick();
      check_val("sq_ch0", ch_val(0), FULL);
      check_val("sq_ch1", ch_val(1), FULL);
      repeat (8) tick();
      drive(1, 1, 1, 256);
      drive(0, 0, 0, 0, 1, 0);
      repeat (12) tick();

      en = 2'b01;
      repeat (8) tick();
      en = 2'b11;
      repeat (8) tick();
      async_reset();
      en = 2'b11;
      repeat (6) tick();

      for (int i = 0; i < 4000; i++) begin
         cfg_wr  = ($urandom % 3 == 0);
         cfg_ch  = 1'($urandom);
         cfg_sel = 2'($urandom);
         case (cfg_sel)
            2'd0: case ($urandom % 3)
                     0: cfg_data = ACC_W'($urandom);
                     1: cfg_data = ACC_W'(1024 * $urandom_range(1, 16));
                     default: cfg_data = ACC_W'(1 << 22);
                  endcase
            2'd2: cfg_data = ACC_W'($urandom_range(0, 400));
            default: cfg_data = ACC_W'($urandom);
         endcase
         cfg_commit = ($urandom % 8 == 0);
         cfg_sync   = 1'($urandom);
         if ($urandom % 20 == 0) en = N_CH'($urandom);
         tick();
         cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_sync = 1'b0;
         if (i == 2000) async_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
